// File: rtl/kernel_pack.sv
// kernel_pack: packs a narrow coefficient stream into wide kernel-memory words.
//
// Accepts one KER_WIDTH coefficient per in_val/in_rdy handshake. It collects
// GROUP_NB of them, or fewer when in_last ends a load, into one
// GROUP_NB*KER_WIDTH word on wr_data/wr_data_val/wr_data_rdy. Lane i of the
// word sits at bits [i*KER_WIDTH +: KER_WIDTH], and unused lanes of a short
// final word are zero.
//
// The block tracks the memory write address, which wraps modulo MEM_DEPTH.
// When the final word of a load drains, it reports that load's address range
// on ker_start/ker_end together with a one-cycle ker_done pulse.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_data/in_last     coefficient and end-of-load marker
//   in_val/in_rdy       input handshake
//   wr_data             packed word
//   wr_data_val/_rdy    output handshake
//   ker_start/ker_end   first/final word address of the last completed load
//   ker_done            one-cycle pulse when ker_start/ker_end update

// One slot of the pack register.
// clr has priority over wr_en. When a word completes, the accepted value
// bypasses this register (see pack_word) and the slot is cleared.
module kernel_pack_lane #(
  parameter int KER_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 clr,
  input  logic [KER_WIDTH-1:0] din,
  output logic [KER_WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       q <= '0;
    else if (clr)   q <= '0;
    else if (wr_en) q <= din;
  end
endmodule

module kernel_pack #(
  parameter int GROUP_NB   = 4,
  parameter int KER_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16,
  parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KER_WIDTH-1:0]          in_data,
  input  logic                          in_last,
  input  logic                          in_val,
  output logic                          in_rdy,
  output logic [GROUP_NB*KER_WIDTH-1:0] wr_data,
  output logic                          wr_data_val,
  input  logic                          wr_data_rdy,
  output logic [MEM_AWIDTH-1:0]         ker_start,
  output logic [MEM_AWIDTH-1:0]         ker_end,
  output logic                          ker_done
);
  localparam int LW = $clog2(GROUP_NB);
  localparam logic [MEM_AWIDTH-1:0] ADDR_MAX = MEM_AWIDTH'(MEM_DEPTH - 1);

  logic [LW-1:0]                        lane;
  logic [GROUP_NB-1:0][KER_WIDTH-1:0]   pack_q;
  logic [GROUP_NB-1:0][KER_WIDTH-1:0]   pack_word;
  logic                                 in_fire, out_fire, flush;
  logic                                 wr_tag;      // word in wr_data ends a load
  logic                                 first_word;  // next drained word opens a load
  logic [MEM_AWIDTH-1:0]                wr_addr, cur_start;

  // Accept only when the output register is free or drains this cycle.
  // Gating with rst keeps in_rdy low throughout reset.
  assign in_rdy   = rst & (~wr_data_val | wr_data_rdy);
  assign in_fire  = in_val & in_rdy;
  assign out_fire = wr_data_val & wr_data_rdy;
  assign flush    = in_fire & ((lane == LW'(GROUP_NB - 1)) | in_last);

  for (genvar i = 0; i < GROUP_NB; i++) begin : g_lane
    logic sel;
    assign sel = in_fire & (lane == LW'(i));
    kernel_pack_lane #(.KER_WIDTH(KER_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .wr_en (sel),
      .clr   (flush),
      .din   (in_data),
      .q     (pack_q[i])
    );
    // The completing coefficient joins the word without waiting a cycle.
    assign pack_word[i] = sel ? in_data : pack_q[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         lane <= '0;
    else if (flush)   lane <= '0;
    else if (in_fire) lane <= lane + 1'b1;
  end

  // Output word register. A new word may load in the same cycle the old one
  // drains; flush can only happen when the register is free or draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_data     <= '0;
      wr_data_val <= 1'b0;
      wr_tag      <= 1'b0;
    end else if (flush) begin
      wr_data     <= pack_word;
      wr_data_val <= 1'b1;
      wr_tag      <= in_last;
    end else if (out_fire) begin
      wr_data_val <= 1'b0;
    end
  end

  // Address tracking and load-range report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr    <= '0;
      cur_start  <= '0;
      first_word <= 1'b1;
      ker_start  <= '0;
      ker_end    <= '0;
      ker_done   <= 1'b0;
    end else begin
      ker_done <= 1'b0;
      if (out_fire) begin
        wr_addr    <= (wr_addr == ADDR_MAX) ? '0 : wr_addr + 1'b1;
        first_word <= wr_tag;
        if (first_word) cur_start <= wr_addr;
        if (wr_tag) begin
          // For a single-word load, cur_start has not been captured yet.
          ker_start <= first_word ? wr_addr : cur_start;
          ker_end   <= wr_addr;
          ker_done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_kernel_pack.sv
// Bench for kernel_pack.
// It drives directed vectors from a table and runs hand-written multi-cycle
// sequences for stall, reset and address wrap.
// It also runs a random backpressure stream checked by a reference packer.
module tb_kernel_pack;
  logic        clk, rst;
  logic [15:0] in_data;
  logic        in_last, in_val, in_rdy;
  logic [63:0] wr_data;
  logic        wr_data_val, wr_data_rdy;
  logic [15:0] ker_start, ker_end;
  logic        ker_done;

  // Second instance with a tiny address space for the wrap case.
  logic [15:0] c_data;
  logic        c_last, c_val, c_in_rdy;
  logic [63:0] c_wr_data;
  logic        c_wr_val, c_wr_rdy;
  logic [2:0]  c_ks, c_ke;
  logic        c_done;

  kernel_pack #(.GROUP_NB(4), .KER_WIDTH(16), .MEM_AWIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_last(in_last), .in_val(in_val),
    .in_rdy(in_rdy), .wr_data(wr_data), .wr_data_val(wr_data_val),
    .wr_data_rdy(wr_data_rdy), .ker_start(ker_start), .ker_end(ker_end),
    .ker_done(ker_done));

  kernel_pack #(.GROUP_NB(4), .KER_WIDTH(16), .MEM_AWIDTH(3), .MEM_DEPTH(8)) dut_w (
    .clk(clk), .rst(rst), .in_data(c_data), .in_last(c_last), .in_val(c_val),
    .in_rdy(c_in_rdy), .wr_data(c_wr_data), .wr_data_val(c_wr_val),
    .wr_data_rdy(c_wr_rdy), .ker_start(c_ks), .ker_end(c_ke), .ker_done(c_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference packer / scoreboard (dut) ----------------
  typedef struct { logic [63:0] w; logic l; } ew_t;
  ew_t         exp_q[$];
  logic [15:0] m_pack[4];
  int          m_lane;
  logic [15:0] m_addr, m_load_start;
  logic        m_open;            // a load has emitted at least one word
  logic        pend;
  logic [15:0] pend_ks, pend_ke;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) m_pack[i] = '0;
      m_lane = 0; m_addr = '0; m_load_start = '0; m_open = 1'b0; pend = 1'b0;
    end else begin
      if (ker_done) done_cnt++;
      if (pend || ker_done) begin
        chk("sb_ker_done", 64'(ker_done), 64'(pend));
        if (pend) begin
          chk("sb_ker_start", 64'(ker_start), 64'(pend_ks));
          chk("sb_ker_end", 64'(ker_end), 64'(pend_ke));
        end
      end
      pend = 1'b0;
      if (wr_data_val && wr_data_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_extra_word: got %h want none", wr_data);
        end else begin
          ew_t e;
          e = exp_q.pop_front();
          chk("sb_wr_data", wr_data, e.w);
          if (!m_open) m_load_start = m_addr;
          m_open = 1'b1;
          if (e.l) begin
            pend = 1'b1; pend_ks = m_load_start; pend_ke = m_addr; m_open = 1'b0;
          end
        end
        m_addr = m_addr + 16'd1;
      end
      if (in_val && in_rdy) begin
        m_pack[m_lane] = in_data;
        if (m_lane == 3 || in_last) begin
          exp_q.push_back('{w: {m_pack[3], m_pack[2], m_pack[1], m_pack[0]}, l: in_last});
          for (int i = 0; i < 4; i++) m_pack[i] = '0;
          m_lane = 0;
        end else m_lane++;
      end
    end
  end

  // ker_done recorder for the wrap instance
  int         c_n = 0;
  logic [2:0] c_ks_r[4], c_ke_r[4];
  always @(negedge clk) if (c_done) begin
    if (c_n < 4) begin c_ks_r[c_n] = c_ks; c_ke_r[c_n] = c_ke; end
    c_n++;
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v; logic [15:0] d; logic l;
    logic ev; logic [63:0] ew; logic ed; logic [15:0] eks, eke;
  } vec_t;
  vec_t tbl[17];

  task automatic row(input int i, input logic v, input logic [15:0] d, input logic l,
                     input logic ev, input logic [63:0] ew,
                     input logic ed, input logic [15:0] eks, input logic [15:0] eke);
    tbl[i] = '{v: v, d: d, l: l, ev: ev, ew: ew, ed: ed, eks: eks, eke: eke};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, lasts, done_base;
    logic [15:0] cd; logic cl;

    rst = 1'b0; in_data = '0; in_last = 1'b0; in_val = 1'b0; wr_data_rdy = 1'b0;
    c_data = '0; c_last = 1'b0; c_val = 1'b0; c_wr_rdy = 1'b1;

    // load 1: 1..8, last on 8 (lane-3 completion, no extra word)
    row(0, 1, 16'd1, 0, 0, 64'h0, 0, 0, 0);
    row(1, 1, 16'd2, 0, 0, 64'h0, 0, 0, 0);
    row(2, 1, 16'd3, 0, 0, 64'h0, 0, 0, 0);
    row(3, 1, 16'd4, 0, 1, 64'h0004_0003_0002_0001, 0, 0, 0);
    row(4, 1, 16'd5, 0, 0, 64'h0, 0, 0, 0);
    row(5, 1, 16'd6, 0, 0, 64'h0, 0, 0, 0);
    row(6, 1, 16'd7, 0, 0, 64'h0, 0, 0, 0);
    row(7, 1, 16'd8, 1, 1, 64'h0008_0007_0006_0005, 0, 0, 0);
    row(8, 0, 16'd0, 0, 0, 64'h0, 1, 16'd0, 16'd1);
    // load 2: 1..5, last on 5 -> zero-padded word, addresses 2..3
    row(9, 1, 16'd1, 0, 0, 64'h0, 0, 0, 0);
    row(10, 1, 16'd2, 0, 0, 64'h0, 0, 0, 0);
    row(11, 1, 16'd3, 0, 0, 64'h0, 0, 0, 0);
    row(12, 1, 16'd4, 0, 1, 64'h0004_0003_0002_0001, 0, 0, 0);
    row(13, 1, 16'd5, 1, 1, 64'h0000_0000_0000_0005, 0, 0, 0);
    row(14, 0, 16'd0, 0, 0, 64'h0, 1, 16'd2, 16'd3);
    // load 3: single coefficient -> single word at address 4
    row(15, 1, 16'd9, 1, 1, 64'h0000_0000_0000_0009, 0, 0, 0);
    row(16, 0, 16'd0, 0, 0, 64'h0, 1, 16'd4, 16'd4);

    // reset state
    #12;
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_wr_val", 64'(wr_data_val), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_ker_done", 64'(ker_done), 64'd0);
    chk("rst_ker_range", {ker_start, ker_end}, 64'd0);
    @(posedge clk); #1; rst = 1'b1; wr_data_rdy = 1'b1;

    for (int i = 0; i < 17; i++) begin
      in_val = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_val", i), 64'(wr_data_val), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), wr_data, tbl[i].ew);
      chk($sformatf("tbl%0d_done", i), 64'(ker_done), 64'(tbl[i].ed));
      if (tbl[i].ed) begin
        chk($sformatf("tbl%0d_ks", i), 64'(ker_start), 64'(tbl[i].eks));
        chk($sformatf("tbl%0d_ke", i), 64'(ker_end), 64'(tbl[i].eke));
      end
    end

    // stall: word pending with wr_data_rdy=0 for 10 cycles
    wr_data_rdy = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_data = 16'(10 + i);
      @(posedge clk); #1;
    end
    in_data = 16'd14;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_in_rdy", 64'(in_rdy), 64'd0);
      chk("stall_val", 64'(wr_data_val), 64'd1);
      chk("stall_data", wr_data, 64'h000D_000C_000B_000A);
    end
    wr_data_rdy = 1'b1;
    @(posedge clk); #1;                     // drain + accept 14 together
    in_data = 16'd15; @(posedge clk); #1;
    in_data = 16'd16; @(posedge clk); #1;
    in_data = 16'd17; in_last = 1'b1; @(posedge clk); #1;
    in_val = 1'b0; in_last = 1'b0;
    chk("stall_next_word", wr_data, 64'h0011_0010_000F_000E);
    @(posedge clk); #1;
    chk("stall_done", 64'(ker_done), 64'd1);
    chk("stall_range", {48'd0, ker_start[7:0], ker_end[7:0]}, 64'h0506);

    // async reset mid-word
    for (int i = 0; i < 6; i++) begin
      in_val = 1'b1; in_data = 16'(16'h31 + i);
      @(posedge clk); #1;
    end
    in_val = 1'b0;
    #3; rst = 1'b0; #1;
    chk("arst_wr_data", wr_data, 64'd0);
    chk("arst_val", 64'(wr_data_val), 64'd0);
    chk("arst_in_rdy", 64'(in_rdy), 64'd0);
    chk("arst_range", {ker_start, ker_end}, 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1; in_data = 16'(16'h21 + i); in_last = (i == 3);
      @(posedge clk); #1;
    end
    in_val = 1'b0; in_last = 1'b0;
    chk("arst_new_word", wr_data, 64'h0024_0023_0022_0021);
    @(posedge clk); #1;
    chk("arst_done", 64'(ker_done), 64'd1);
    chk("arst_range_new", {ker_start, ker_end}, 64'd0);

    // wrap: MEM_DEPTH=8, loads of 12 coefficients (3 words each)
    for (int i = 1; i <= 40; i++) begin
      c_val = 1'b1; c_data = 16'(i); c_last = (i % 12 == 0);
      @(posedge clk); #1;
    end
    c_val = 1'b0; c_last = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("wrap_done_cnt", 64'(c_n), 64'd3);
    if (c_n >= 3) begin
      chk("wrap_l1", {c_ks_r[0], c_ke_r[0]}, 64'(6'o02));
      chk("wrap_l2", {c_ks_r[1], c_ke_r[1]}, 64'(6'o35));
      chk("wrap_l3", {c_ks_r[2], c_ke_r[2]}, 64'(6'o60));
    end

    // random backpressure, 10k coefficients
    done_base = done_cnt; lasts = 0; idx = 0; cyc = 0;
    cd = 16'($urandom); cl = ($urandom_range(9) == 0);
    while (idx < 10000 && cyc < 60000) begin
      wr_data_rdy = ($urandom_range(3) != 0);
      in_val = ($urandom_range(3) != 0);
      in_data = cd; in_last = cl;
      @(negedge clk);
      if (in_val && in_rdy) begin
        idx++;
        if (cl) lasts++;
        cd = 16'($urandom);
        cl = (idx == 9999) || ($urandom_range(9) == 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_val = 1'b0; in_last = 1'b0; wr_data_rdy = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("rand_coef_count", 64'(idx), 64'd10000);
    chk("rand_done_count", 64'(done_cnt - done_base), 64'(lasts));
    chk("rand_sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kernel_pack.md
# kernel_pack

Upstream feeder for the kernel memory write port. Accepts kernel coefficients one at a time on a narrow valid/ready stream and packs each run of GROUP_NB values into one GROUP_NB*KER_WIDTH word on a wide valid/ready port. Tracks the memory write address, which wraps modulo MEM_DEPTH, so that it can report the address range of each completed kernel load to the read-side configuration logic.

## Interface
- GROUP_NB, 4, coefficients per packed word (≥2)
- KER_WIDTH, 16, bits per coefficient
- MEM_AWIDTH, 16, kernel memory address width
- MEM_DEPTH, 1<<MEM_AWIDTH, kernel memory depth in words
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-low
- in_data  in  KER_WIDTH  coefficient
- in_last  in  1  final coefficient of the current kernel load
- in_val  in  1  in_data/in_last valid
- in_rdy  out  1  block accepts input
- wr_data  out  GROUP_NB*KER_WIDTH  packed word; lane i is at bits [i*KER_WIDTH +: KER_WIDTH]
- wr_data_val  out  1  packed word valid
- wr_data_rdy  in  1  downstream accepts word
- ker_start  out  MEM_AWIDTH  address of the first word of the last completed load
- ker_end  out  MEM_AWIDTH  address of the final word of the last completed load
- ker_done  out  1  one-cycle pulse: ker_start/ker_end updated

## Operation
- Input handshake on in_val & in_rdy. Output handshake on wr_data_val & wr_data_rdy.
- in_rdy = ~wr_data_val | wr_data_rdy. The input side never overwrites an unconsumed output word. in_rdy is forced to 0 while rst is asserted.
- Lane counter lane (0..GROUP_NB-1) selects the pack-register slot. The first accepted coefficient of a word goes to lane 0.
- On accept, the coefficient is written to pack[lane].
  - If lane==GROUP_NB-1 or in_last, the pack register (including the value being accepted) moves to the wr_data register. wr_data_val is set, lane goes to 0, and the pack register is cleared to zero. This clearing zero-fills the unused lanes of a short final word.
  - Otherwise lane increments.
- A tag bit travels with the output word to mark it as the final word of a load, meaning in_last was seen while it was packed.
- wr_addr (MEM_AWIDTH) holds the address the next emitted word will occupy. It increments on each output handshake and wraps from MEM_DEPTH-1 to 0. cur_start latches wr_addr at the first output handshake of each load.
- On the output handshake of a tagged word:
  - ker_start <= cur_start (or wr_addr if the load is a single word)
  - ker_end <= wr_addr
  - ker_done pulses
- Loads follow one another back-to-back with no gap required. Each load starts packing at lane 0.
- in_last on a coefficient that also fills lane GROUP_NB-1 produces exactly one word, with no extra empty word.
- Reset (asynchronous):
  - lane=0, pack=0, wr_data=0, wr_data_val=0, tag=0
  - wr_addr=0, cur_start=0, ker_start=0, ker_end=0, ker_done=0
  - A partially packed word is discarded. Reset mid-load abandons the load without a ker_done pulse.

## Timing
- Latency: from the handshake of the completing coefficient to wr_data_val high is 1 cycle (registered).
- Throughput: one coefficient per cycle while wr_data_rdy=1. One word every GROUP_NB cycles.
- With wr_data_val=1 and wr_data_rdy=1, the output word can be replaced in the same cycle it drains. There is no bubble.
- With wr_data_val=1 and wr_data_rdy=0:
  - in_rdy=0
  - wr_data and wr_data_val hold stable
  - the pack register and lane hold
- ker_done is asserted in the cycle after the tagged word's output handshake. It is high for exactly 1 cycle. ker_start and ker_end change only in that same cycle and hold otherwise.
- wr_data_val never drops without a handshake.
- At wrap, the address after MEM_DEPTH-1 is 0. ker_end may be numerically less than ker_start; consumers treat the range as circular.

## Test plan
- GROUP_NB=4, KER_WIDTH=16, wr_data_rdy=1, stream 1..8 with in_last on 8 → wr_data 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005 on consecutive handshakes; ker_done once with ker_start=0, ker_end=1.
- Stream 1..5 with in_last on 5 → second word 0x0000_0000_0000_0005; ker_end=1. The next load starts at lane 0 and its first word lands at address 2 (ker_start=2).
- Hold wr_data_rdy=0 for 10 cycles with a word pending → in_rdy=0 and wr_data stable throughout; on release, no coefficients are lost or duplicated (scoreboard vs. reference packer).
- MEM_AWIDTH=3: stream 40 coefficients as loads of 12 → wr_addr wraps. Third load reports ker_start=6, ker_end=0; ker_done pulses 3 times.
- Assert rst mid-word after 2 coefficients → all outputs are 0 immediately (async). After release, a fresh 4-coefficient load emits one word at address 0 containing only the new data.
- Random in_val/wr_data_rdy backpressure over 10k coefficients with random in_last → output words, zero padding and ker_start/ker_end match the model; ker_done count equals the number of in_last.
